// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and defaults for the data-memory access arbiter
package dm_arb_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 32;
    localparam int DM_WORDS_DEF = 1024;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dm_access_arbiter_if.sv
// rtl/dm_access_arbiter_if.sv - requester and memory-side signal bundle for dm_access_arbiter
interface dm_access_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [31:0]       m0_pc;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [31:0]       m1_pc;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [31:0]       mem_wpc;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_pc,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_pc,
        input  mem_rdata,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err,
        output mem_write, mem_read, mem_addr, mem_wdata, mem_wpc
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_pc,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_pc,
        output mem_rdata,
        input  m0_ack, m0_rdata, m0_err,
        input  m1_ack, m1_rdata, m1_err,
        input  mem_write, mem_read, mem_addr, mem_wdata, mem_wpc
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick
module rr_arbiter2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    // On a tie the port that did not win last time goes first; otherwise the lone requester wins.
    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        gnt_idx_o   = (req0_i & req1_i) ? ~last_i : req1_i;
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// rtl/dm_access_arbiter.sv - round-robin sharing of the single-port data memory; optional DM_ARB_ADDR_CHECK_EN
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DM_WORDS = DM_WORDS_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dm_access_arbiter_if.slave bus
);

`ifdef DM_ARB_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    logic              idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              gnt_valid;
    logic              gnt_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] sel_word;
    logic [DATA_W-1:0] sel_wdata;
    logic [31:0]       sel_pc;
    logic              sel_bad;
    logic              resp;

    rr_arbiter2 u_rr (
        .req0_i      (bus.m0_req),
        .req1_i      (bus.m1_req),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Mux the winning requester's fields and flag misaligned or out-of-range addresses.
    always_comb begin
        sel_we    = (gnt_idx == PORT1) ? bus.m1_we    : bus.m0_we;
        sel_addr  = (gnt_idx == PORT1) ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = (gnt_idx == PORT1) ? bus.m1_wdata : bus.m0_wdata;
        sel_pc    = (gnt_idx == PORT1) ? bus.m1_pc    : bus.m0_pc;
        sel_word  = sel_addr >> 2;
        sel_bad   = CHECK_EN && ((sel_addr[1:0] != 2'b00) || (sel_word >= ADDR_W'(DM_WORDS)));
    end

    // State and grant latches; everything returns to its idle value on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= PORT1;
            idx_q   <= PORT0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next state: grant and latch in IDLE, capture read data in ACCESS, release in RESP.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    idx_d   = gnt_idx;
                    last_d  = gnt_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    pc_d    = sel_pc;
                    err_d   = sel_bad;
                    state_d = sel_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = bus.mem_rdata;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory side is live only in ACCESS; a write coinciding with reset is suppressed.
    always_comb begin
        bus.mem_write = (state_q == ACCESS) && we_q && !rst_i;
        bus.mem_read  = (state_q == ACCESS) && !we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wpc   = pc_q;
    end

    // Response to the granted port; read data only for successful reads.
    always_comb begin
        resp         = (state_q == RESP) && !rst_i;
        bus.m0_ack   = resp && (idx_q == PORT0);
        bus.m1_ack   = resp && (idx_q == PORT1);
        bus.m0_err   = bus.m0_ack && err_q;
        bus.m1_err   = bus.m1_ack && err_q;
        bus.m0_rdata = (bus.m0_ack && !we_q && !err_q) ? rdata_q : '0;
        bus.m1_rdata = (bus.m1_ack && !we_q && !err_q) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb/tb_dm_access_arbiter.sv - directed self-checking bench for dm_access_arbiter
module tb_dm_access_arbiter;

`ifdef DM_ARB_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem [0:1023];
    logic        pre_en;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;
    int          write_cnt;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    dm_access_arbiter_if bus ();

    dm_access_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .DM_WORDS (1024)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_data;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
            write_cnt  <= write_cnt + 1;
            last_waddr <= bus.mem_addr;
            last_wdata <= bus.mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_idx  = idx;
        pre_data = data;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic access(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int wr_at,
                          output logic [31:0] rdata, output logic err);
        @(negedge clk);
        if (port) begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_pc = 32'h100; bus.m1_req = 1'b1;
        end else begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_pc = 32'h200; bus.m0_req = 1'b1;
        end
        lat = -1; wr_at = -1; rdata = 'x; err = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_write && wr_at < 0) wr_at = c;
            if (port ? bus.m1_ack : bus.m0_ack) begin
                lat   = c;
                rdata = port ? bus.m1_rdata : bus.m0_rdata;
                err   = port ? bus.m1_err : bus.m0_err;
                break;
            end
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
    endtask

    int          lat, wr_at, wc0, n_ack, ack_seen, first_at, second_at;
    int          order [4];
    bit          rearm0, rearm1;
    logic [31:0] rd, d0, d1;
    logic        er;

    initial begin
        n_checks = 0; n_fail = 0;
        write_cnt = 0; last_waddr = '0; last_wdata = '0;
        pre_en = 1'b0; pre_idx = '0; pre_data = '0;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_pc = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_pc = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_acks", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}, 4'b0000);
        check_eq("reset_mem_ctl", {bus.mem_write, bus.mem_read}, 2'b00);
        check_eq("reset_mem_addr", bus.mem_addr, 32'h0);

        // Simultaneous requests straight after reset: port 0 first, then alternation.
        for (int i = 0; i < 4; i++) order[i] = -1;
        n_ack = 0; rearm0 = 0; rearm1 = 0;
        @(negedge clk);
        bus.m0_we = 0; bus.m0_addr = 32'h40; bus.m1_we = 0; bus.m1_addr = 32'h44;
        bus.m0_req = 1; bus.m1_req = 1;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            @(negedge clk);
            if (rearm0) begin bus.m0_req = 1; rearm0 = 0; end
            if (rearm1) begin bus.m1_req = 1; rearm1 = 0; end
            if (bus.m0_ack) begin order[n_ack] = 0; n_ack++; bus.m0_req = 0; rearm0 = 1; end
            if (bus.m1_ack) begin order[n_ack] = 1; n_ack++; bus.m1_req = 0; rearm1 = 1; end
        end
        bus.m0_req = 0; bus.m1_req = 0;
        check_eq("tie_ack_count", n_ack, 4);
        check_eq("tie_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_01_00_01);

        // Write from port 0, read back through port 1.
        wc0 = write_cnt;
        access(0, 1, 32'h10, 32'hDEADBEEF, lat, wr_at, rd, er);
        check_eq("wr_access_cycle", wr_at, 1);
        check_eq("wr_ack_latency", lat, 2);
        check_eq("wr_mem_addr", last_waddr, 32'h10);
        check_eq("wr_mem_wdata", last_wdata, 32'hDEADBEEF);
        check_eq("wr_count", write_cnt - wc0, 1);
        check_eq("wr_rdata_zero", rd, 32'h0);
        check_eq("wr_err", er, 1'b0);
        access(1, 0, 32'h10, 32'h0, lat, wr_at, rd, er);
        check_eq("rd_ack_latency", lat, 2);
        check_eq("rd_data", rd, 32'hDEADBEEF);

        // Reset during a port 1 write's ACCESS cycle.
        preload(10'd8, 32'hAAAA5555);
        wc0 = write_cnt;
        @(negedge clk);
        bus.m1_we = 1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h12345678; bus.m1_req = 1;
        @(negedge clk);
        check_eq("abort_in_access", bus.mem_write, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("abort_write_gated", bus.mem_write, 1'b0);
        bus.m1_req = 0;
        ack_seen = 0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_idle_ctl", {bus.mem_write, bus.mem_read}, 2'b00);
        for (int c = 0; c < 4; c++) begin
            if (bus.m1_ack || bus.m0_ack) ack_seen++;
            @(negedge clk);
        end
        check_eq("abort_no_ack", ack_seen, 0);
        check_eq("abort_no_write", write_cnt - wc0, 0);
        access(0, 0, 32'h20, 32'h0, lat, wr_at, rd, er);
        check_eq("abort_reread_lat", lat, 2);
        check_eq("abort_reread_data", rd, 32'hAAAA5555);

        // Back-to-back reads with req held continuously.
        preload(10'd0, 32'h11111111);
        preload(10'd1, 32'h22222222);
        first_at = -1; second_at = -1; d0 = '0; d1 = '0;
        @(negedge clk);
        bus.m0_we = 0; bus.m0_addr = 32'h0; bus.m0_req = 1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.m0_ack) begin
                if (first_at < 0) begin
                    first_at = c; d0 = bus.m0_rdata; bus.m0_addr = 32'h4;
                end else begin
                    second_at = c; d1 = bus.m0_rdata; bus.m0_req = 0;
                    break;
                end
            end
        end
        bus.m0_req = 0;
        check_eq("b2b_first_at", first_at, 2);
        check_eq("b2b_second_at", second_at, 5);
        check_eq("b2b_data0", d0, 32'h11111111);
        check_eq("b2b_data1", d1, 32'h22222222);

        // Address checks: misaligned write, out-of-range read, last valid word.
        wc0 = write_cnt;
        access(0, 1, 32'h6, 32'hCAFEF00D, lat, wr_at, rd, er);
        check_eq("mis_lat", lat, CHK ? 1 : 2);
        check_eq("mis_err", er, CHK);
        check_eq("mis_writes", write_cnt - wc0, CHK ? 0 : 1);
        access(1, 0, 32'h1000, 32'h0, lat, wr_at, rd, er);
        check_eq("oor_lat", lat, CHK ? 1 : 2);
        check_eq("oor_err", er, CHK);
        check_eq("oor_rdata", rd, CHK ? 32'h0 : 32'h11111111);
        preload(10'd1023, 32'h5A5A5A5A);
        access(1, 0, 32'hFFC, 32'h0, lat, wr_at, rd, er);
        check_eq("top_word_lat", lat, 2);
        check_eq("top_word_err", er, 1'b0);
        check_eq("top_word_data", rd, 32'h5A5A5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
